output_queue_bank: RTL and testbench

//  Per-destination output queues directly downstream of the crossbar mux controller.

---
 rtl/output_queue_bank_pkg.sv | 15 +
 rtl/output_queue_bank_oq_fifo.sv | 88 ++++++++
 rtl/output_queue_bank.sv | 45 ++++
 tb/tb_output_queue_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_queue_bank_pkg.sv
// Shared constants for the output queue bank: port count and per-queue defaults,
// plus the occupancy-width helper used wherever a queue count is carried.
package output_queue_bank_pkg;

  localparam int PORT_NUB_TOTAL = 4;
  localparam int OQ_DATA_WIDTH  = 32;
  localparam int OQ_DEPTH       = 16;
  localparam int OQ_FULL_MARGIN = 3;

  // Occupancy must hold 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int oq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/output_queue_bank_oq_fifo.sv
// Single-port first-word-fall-through FIFO with occupancy, almost-full and sticky
// overflow. One instance sits behind each crossbar output port.
module oq_fifo
  import output_queue_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = OQ_DATA_WIDTH,
  parameter int DEPTH       = OQ_DEPTH,
  parameter int FULL_MARGIN = OQ_FULL_MARGIN,
  localparam int CNT_W      = oq_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count_out,
  output logic                  ovf_out,
  input  logic                  ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(DEPTH - FULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  // Handshake decode and next-state for pointers, occupancy, almost-full and overflow.
  always_comb begin
    pop      = (count_q != '0) & out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    push     = wr_in & ((count_q < DEPTH_C) | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Almost-full is registered so the controller sees a clean flop output
    // that always equals the decode of the registered count.
    full_d = (count_d >= AFULL_C);
    ovf_d  = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    // A new drop overrides a same-cycle clear.
    if (wr_in & ~push) ovf_d = 1'b1;
  end

  // Control state; reset discards all queued words by emptying the pointers/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count_out = count_q;
  assign full_out  = full_q;
  assign ovf_out   = ovf_q;

endmodule

// File: rtl/output_queue_bank.sv
// Bank of independent per-destination output queues fed by the crossbar mux
// controller. Only instantiation and bus slicing live here.
module output_queue_bank
  import output_queue_bank_pkg::*;
#(
  parameter int PORT_NUB    = PORT_NUB_TOTAL,
  parameter int DATA_WIDTH  = OQ_DATA_WIDTH,
  parameter int DEPTH       = OQ_DEPTH,
  parameter int FULL_MARGIN = OQ_FULL_MARGIN,
  localparam int CNT_W      = oq_cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUB-1:0]            wr_in,
  input  logic [PORT_NUB*DATA_WIDTH-1:0] data_in,
  output logic [PORT_NUB-1:0]            full_out,
  output logic [PORT_NUB-1:0]            out_valid,
  output logic [PORT_NUB*DATA_WIDTH-1:0] out_data,
  input  logic [PORT_NUB-1:0]            out_ready,
  output logic [PORT_NUB*CNT_W-1:0]      count_out,
  output logic [PORT_NUB-1:0]            ovf_out,
  input  logic [PORT_NUB-1:0]            ovf_clr
);

  for (genvar i = 0; i < PORT_NUB; i++) begin : g_port
    oq_fifo #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH       (DEPTH),
      .FULL_MARGIN (FULL_MARGIN)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_in     (wr_in[i]),
      .data_in   (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .full_out  (full_out[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_ready (out_ready[i]),
      .count_out (count_out[i*CNT_W +: CNT_W]),
      .ovf_out   (ovf_out[i]),
      .ovf_clr   (ovf_clr[i])
    );
  end

endmodule

// File: tb/tb_output_queue_bank.sv
// Bench for output_queue_bank: vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference of the bank.
module tb_output_queue_bank;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FM    = 3;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     wr_in, full_out, out_valid, out_ready, ovf_out, ovf_clr;
  logic [NP*DW-1:0]  data_in, out_data;
  logic [NP*CW-1:0]  count_out;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: one plain queue of words per port plus a sticky overflow flag.
  logic [7:0] mq [NP][$];
  bit         movf [NP];

  typedef struct {
    logic [3:0]  wr;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic [3:0]  clr;
    logic [3:0]  e_full;
    logic [3:0]  e_valid;
    logic [3:0]  e_ovf;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  output_queue_bank #(
    .PORT_NUB    (NP),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .FULL_MARGIN (FM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_in     (wr_in),
    .data_in   (data_in),
    .full_out  (full_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count_out (count_out),
    .ovf_out   (ovf_out),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
  endfunction

  function automatic vec_t mk(logic [3:0] wr, logic [31:0] data, logic [3:0] rdy,
                              logic [3:0] clr, logic [3:0] e_full, logic [3:0] e_valid,
                              logic [3:0] e_ovf, logic [15:0] e_cnt);
    vec_t v;
    v.wr = wr; v.data = data; v.rdy = rdy; v.clr = clr;
    v.e_full = e_full; v.e_valid = e_valid; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      movf[i] = 1'b0;
    end
  endfunction

  // One clock edge of the bank as the behaviour rules describe it.
  function automatic void model_step(logic [3:0] wr, logic [31:0] d, logic [3:0] rdy,
                                     logic [3:0] clr);
    for (int i = 0; i < NP; i++) begin
      bit pop_m, push_m;
      pop_m  = (mq[i].size() != 0) && rdy[i];
      push_m = wr[i] && ((mq[i].size() < DEPTH) || pop_m);
      if (pop_m)  void'(mq[i].pop_front());
      if (push_m) mq[i].push_back(d[8*i +: 8]);
      if (clr[i]) movf[i] = 1'b0;
      if (wr[i] && !push_m) movf[i] = 1'b1;
    end
  endfunction

  function automatic void check_model(string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s count[%0d]", tag, i), 32'(count_out[CW*i +: CW]), 32'(mq[i].size()));
      chk($sformatf("%s valid[%0d]", tag, i), 32'(out_valid[i]), 32'(mq[i].size() != 0));
      chk($sformatf("%s full[%0d]", tag, i), 32'(full_out[i]), 32'(mq[i].size() >= DEPTH - FM));
      chk($sformatf("%s ovf[%0d]", tag, i), 32'(ovf_out[i]), 32'(movf[i]));
      if (mq[i].size() != 0)
        chk($sformatf("%s data[%0d]", tag, i), 32'(out_data[8*i +: 8]), 32'(mq[i][0]));
    end
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic cycle(input logic [3:0] wr, input logic [31:0] d, input logic [3:0] rdy,
                       input logic [3:0] clr, input string tag);
    wr_in = wr; data_in = d; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_step(wr, d, rdy, clr);
    #1;
    wr_in = '0; data_in = '0; out_ready = '0; ovf_clr = '0;
    check_model(tag);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_model("async_rst");
    chk("rst count_out", 32'(count_out), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst full_out", 32'(full_out), 32'h0);
    chk("rst ovf_out", 32'(ovf_out), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp3 [8];
    int         tagseq [NP];
    logic [3:0] w, r, c;
    logic [31:0] d;

    rst = 1'b1;
    wr_in = '0; data_in = '0; out_ready = '0; ovf_clr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset count_out", 32'(count_out), 32'h0);
    rst = 1'b0;

    // Almost-full on port 0, then overflow and clear on port 1.
    tbl.push_back(mk(4'b0001, 32'h0000_0010, 4'h0, 4'h0, 4'b0000, 4'b0001, 4'h0, 16'h0001));
    tbl.push_back(mk(4'b0001, 32'h0000_0011, 4'h0, 4'h0, 4'b0000, 4'b0001, 4'h0, 16'h0002));
    tbl.push_back(mk(4'b0001, 32'h0000_0012, 4'h0, 4'h0, 4'b0000, 4'b0001, 4'h0, 16'h0003));
    tbl.push_back(mk(4'b0001, 32'h0000_0013, 4'h0, 4'h0, 4'b0000, 4'b0001, 4'h0, 16'h0004));
    tbl.push_back(mk(4'b0001, 32'h0000_0014, 4'h0, 4'h0, 4'b0001, 4'b0001, 4'h0, 16'h0005));
    tbl.push_back(mk(4'b0010, 32'h0000_0000, 4'h0, 4'h0, 4'b0001, 4'b0011, 4'h0, 16'h0015));
    tbl.push_back(mk(4'b0010, 32'h0000_0100, 4'h0, 4'h0, 4'b0001, 4'b0011, 4'h0, 16'h0025));
    tbl.push_back(mk(4'b0010, 32'h0000_0200, 4'h0, 4'h0, 4'b0001, 4'b0011, 4'h0, 16'h0035));
    tbl.push_back(mk(4'b0010, 32'h0000_0300, 4'h0, 4'h0, 4'b0001, 4'b0011, 4'h0, 16'h0045));
    tbl.push_back(mk(4'b0010, 32'h0000_0400, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'h0, 16'h0055));
    tbl.push_back(mk(4'b0010, 32'h0000_0500, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'h0, 16'h0065));
    tbl.push_back(mk(4'b0010, 32'h0000_0600, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'h0, 16'h0075));
    tbl.push_back(mk(4'b0010, 32'h0000_0700, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'h0, 16'h0085));
    tbl.push_back(mk(4'b0010, 32'h0000_0800, 4'h0, 4'h0, 4'b0011, 4'b0011, 4'b0010, 16'h0085));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'h0, 4'b0010, 4'b0011, 4'b0011, 4'h0, 16'h0085));

    foreach (tbl[k]) begin
      cycle(tbl[k].wr, tbl[k].data, tbl[k].rdy, tbl[k].clr, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d full_out", k), 32'(full_out), 32'(tbl[k].e_full));
      chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      chk($sformatf("vec%0d ovf_out", k), 32'(ovf_out), 32'(tbl[k].e_ovf));
      chk($sformatf("vec%0d count_out", k), 32'(count_out), 32'(tbl[k].e_cnt));
    end

    // Port 1 drains 0x00..0x07; the ninth word was dropped.
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain1 head%0d", j), 32'(out_data[15:8]), 32'(j));
      cycle(4'b0000, 32'h0, 4'b0010, 4'h0, "drain1");
    end
    chk("drain1 empty", 32'(out_valid[1]), 32'h0);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("drain0 head%0d", j), 32'(out_data[7:0]), 32'(8'h10 + j));
      cycle(4'b0000, 32'h0, 4'b0001, 4'h0, "drain0");
    end

    // Full queue on port 3 takes a word when the head pops in the same cycle.
    for (int j = 0; j < 8; j++)
      cycle(4'b1000, {8'(8'h30 + j), 24'h0}, 4'h0, 4'h0, "fill3");
    cycle(4'b1000, 32'h3F00_0000, 4'b1000, 4'h0, "pushpop3");
    chk("pushpop3 count", 32'(count_out[15:12]), 32'd8);
    chk("pushpop3 ovf", 32'(ovf_out[3]), 32'h0);
    for (int j = 0; j < 7; j++) exp3[j] = 8'h31 + 8'(j);
    exp3[7] = 8'h3F;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain3 head%0d", j), 32'(out_data[31:24]), 32'(exp3[j]));
      cycle(4'b0000, 32'h0, 4'b1000, 4'h0, "drain3");
    end

    // One-cycle write-to-visible latency with ready held.
    cycle(4'b0001, 32'h0000_00AB, 4'b0001, 4'h0, "lat_wr");
    chk("lat valid", 32'(out_valid[0]), 32'h1);
    chk("lat data", 32'(out_data[7:0]), 32'hAB);
    chk("lat count", 32'(count_out[3:0]), 32'h1);
    cycle(4'b0000, 32'h0, 4'b0001, 4'h0, "lat_pop");
    chk("lat drained", 32'(count_out[3:0]), 32'h0);

    // Mid-stream reset: port 2 holds 5 words, port 3 has overflowed.
    for (int j = 0; j < 9; j++)
      cycle((j < 5) ? 4'b1100 : 4'b1000, {8'(8'hC0 + j), 8'(8'h50 + j), 16'h0}, 4'h0, 4'h0, "prerst");
    chk("prerst ovf3", 32'(ovf_out[3]), 32'h1);
    chk("prerst count2", 32'(count_out[11:8]), 32'd5);
    apply_reset();
    check_model("postrst");
    cycle(4'b0100, 32'h0077_0000, 4'h0, 4'h0, "rst_wr");
    chk("rst first word", 32'(out_data[23:16]), 32'h77);
    chk("rst count2", 32'(count_out[11:8]), 32'd1);
    cycle(4'b0000, 32'h0, 4'b0100, 4'h0, "rst_pop");

    // Parallel traffic honouring full_out, port-tagged data.
    for (int i = 0; i < NP; i++) tagseq[i] = 0;
    for (int n = 0; n < 400; n++) begin
      w = 4'($urandom) & ~full_out;
      r = 4'($urandom);
      d = '0;
      for (int i = 0; i < NP; i++) begin
        d[8*i +: 8] = {4'(i), 1'b0, 3'(tagseq[i])};
        if (w[i]) tagseq[i]++;
      end
      cycle(w, d, r, 4'h0, "par");
    end
    chk("par no ovf", 32'(ovf_out), 32'h0);

    // Unconstrained traffic including overflow and clears.
    for (int n = 0; n < 400; n++) begin
      w = 4'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cycle(w, $urandom, r, c, "rand");
    end
    for (int n = 0; n < 12; n++) cycle(4'h0, 32'h0, 4'hF, 4'h0, "flush");
    chk("flush empty", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
